// File: rtl/imem_boot_loader.sv
// Instruction-memory image writer: NOP-fills the whole BRAM, then packs a
// little-endian byte stream into 32-bit words while holding the core in reset.
module imem_boot_loader #(
  parameter int          DEPTH    = 512,
  parameter int          ADDR_W   = $clog2(DEPTH),
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow_err,
  output logic              partial_err
);

  typedef enum logic [2:0] {IDLE, FILL, LOAD, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0]   FULL   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   WC_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              load_done_q, load_done_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              overflow_q, overflow_d;
  logic              partial_q, partial_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       buf_q, buf_d;
  logic              take;

  // byte_ready_q is only ever set while in LOAD, so it gates acceptance alone
  assign take = byte_valid & byte_ready_q;

  always_comb begin
    state_d      = state_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    partial_d    = partial_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          state_d      = FILL;
          mem_we_d     = 1'b1;
          mem_addr_d   = '0;
          mem_wdata_d  = NOP_WORD;
          word_count_d = '0;
          overflow_d   = 1'b0;
          partial_d    = 1'b0;
          idx_d        = '0;
        end
      end
      FILL: begin
        if (mem_addr_q == LAST_A) begin
          state_d = LOAD;
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = mem_addr_q + A_ONE;
        end
      end
      LOAD: begin
        if (take) begin
          if (idx_q == 2'd3) begin
            idx_d = '0;
            if (word_count_q == FULL) begin
              overflow_d = 1'b1;
            end else begin
              mem_we_d     = 1'b1;
              mem_addr_d   = word_count_q[ADDR_W-1:0];
              mem_wdata_d  = {byte_data, buf_q};
              word_count_d = word_count_q + WC_ONE;
            end
          end else begin
            buf_d[{idx_q, 3'b000} +: 8] = byte_data;
            idx_d = idx_q + 2'd1;
          end
        end
        // a byte accepted alongside load_end is counted before the pending check
        if (load_end) begin
          state_d = DRAIN;
          if (idx_d != 2'd0) partial_d = 1'b1;
          idx_d = '0;
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    byte_ready_d = (state_d == LOAD);
    core_rst_d   = (state_d != DONE);
    load_done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rst_q   <= 1'b1;
      load_done_q  <= 1'b0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      partial_q    <= 1'b0;
      idx_q        <= '0;
      buf_q        <= '0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rst_q   <= core_rst_d;
      load_done_q  <= load_done_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      partial_q    <= partial_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
    end
  end

  assign byte_ready   = byte_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_rst     = core_rst_q;
  assign load_done    = load_done_q;
  assign word_count   = word_count_q;
  assign overflow_err = overflow_q;
  assign partial_err  = partial_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader at DEPTH=8; memory writes are logged
// on the falling edge and compared against hand-computed words.
module tb_imem_boot_loader;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst, load_start, load_end, byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready, mem_we, core_rst, load_done;
  logic              overflow_err, partial_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];

  imem_boot_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_end(load_end),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .load_done(load_done), .word_count(word_count),
    .overflow_err(overflow_err), .partial_err(partial_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic start_and_fill(input string tag);
    int i;
    wa_q.delete();
    wd_q.delete();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (i = 0; i < 40; i++) begin
      if (byte_ready) break;
      tick();
    end
    chk({tag, "_fill_ready"}, byte_ready, 1'b1);
    chk({tag, "_fill_n"}, wa_q.size(), DEPTH);
    for (int k = 0; k < DEPTH && k < wa_q.size(); k++) begin
      chk($sformatf("%s_fill_a%0d", tag, k), wa_q[k], k);
      chk($sformatf("%s_fill_d%0d", tag, k), wd_q[k], 32'h0000_0013);
    end
    chk({tag, "_fill_corerst"}, core_rst, 1'b1);
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_end = 1'b0;
    byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) tick();
    chk("rst_corerst", core_rst, 1'b1);
    chk("rst_ready", byte_ready, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_done", load_done, 1'b0);
    chk("rst_wc", word_count, 0);
    rst = 1'b0;
    tick();
    chk("idle_corerst", core_rst, 1'b1);

    // two full words
    start_and_fill("l1");
    send(8'h13); send(8'h05); send(8'h50); send(8'h00);
    send(8'h93); send(8'h05); send(8'h10); send(8'h00);
    tick(); tick();
    chk("l1_nwr", wd_q.size(), 2);
    if (wd_q.size() == 2) begin
      chk("l1_a0", wa_q[0], 0); chk("l1_d0", wd_q[0], 32'h0050_0513);
      chk("l1_a1", wa_q[1], 1); chk("l1_d1", wd_q[1], 32'h0010_0593);
    end
    chk("l1_wc", word_count, 2);

    // partial word then load_end
    wa_q.delete(); wd_q.delete();
    send(8'h13); send(8'h05);
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    chk("l1_drain_ready", byte_ready, 1'b0);
    chk("l1_drain_done", load_done, 1'b0);
    chk("l1_partial", partial_err, 1'b1);
    tick();
    chk("l1_done", load_done, 1'b1);
    chk("l1_core_run", core_rst, 1'b0);
    chk("l1_done_ready", byte_ready, 1'b0);
    chk("l1_nowrite", wd_q.size(), 0);
    chk("l1_wc_end", word_count, 2);

    // overflow: 36 bytes into 8 words, start from DONE
    start_and_fill("l2");
    chk("l2_partial_clr", partial_err, 1'b0);
    chk("l2_wc_clr", word_count, 0);
    for (int i = 0; i < 36; i++) send(8'(i));
    tick(); tick();
    chk("l2_nwr", wd_q.size(), DEPTH);
    for (int k = 0; k < DEPTH && k < wd_q.size(); k++) begin
      chk($sformatf("l2_a%0d", k), wa_q[k], k);
      chk($sformatf("l2_d%0d", k), wd_q[k],
          {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    end
    chk("l2_wc", word_count, DEPTH);
    chk("l2_ovf", overflow_err, 1'b1);
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    tick();
    chk("l2_partial", partial_err, 1'b0);
    chk("l2_done", load_done, 1'b1);

    // 4th byte coincident with load_end
    start_and_fill("l3");
    chk("l3_ovf_clr", overflow_err, 1'b0);
    send(8'hAA); send(8'hBB); send(8'hCC);
    byte_valid = 1'b1; byte_data = 8'hDD; load_end = 1'b1;
    tick();
    byte_valid = 1'b0; load_end = 1'b0;
    tick(); tick();
    chk("l3_nwr", wd_q.size(), 1);
    if (wd_q.size() == 1) begin
      chk("l3_a0", wa_q[0], 0);
      chk("l3_d0", wd_q[0], 32'hDDCC_BBAA);
    end
    chk("l3_partial", partial_err, 1'b0);
    chk("l3_done", load_done, 1'b1);
    chk("l3_core_run", core_rst, 1'b0);
    chk("l3_wc", word_count, 1);

    // reset in the middle of LOAD
    start_and_fill("l4");
    send(8'h11); send(8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("l4_corerst", core_rst, 1'b1);
    chk("l4_ready", byte_ready, 1'b0);
    chk("l4_done", load_done, 1'b0);
    chk("l4_wc", word_count, 0);
    chk("l4_we", mem_we, 1'b0);
    byte_valid = 1'b1; byte_data = 8'h33;
    tick(); tick();
    byte_valid = 1'b0;
    chk("l4_idle_ready", byte_ready, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
